mem_writein_demux: RTL and testbench

//  Receiving end of the memory-readout stream: accepts the serialized {BX,src,data} words emitted by the

---
 rtl/mem_writein_demux.sv | 204 ++++++++++++++++++++
 tb/tb_mem_writein_demux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writein_demux.sv
// mem_writein_demux: receives serialized {bx, src, data} readout words and writes
// them back into NMEM ping-pong data memories over one shared write bus.
// Per-memory item counts are kept per event. On new_event the counts are
// flushed into the nitems line of each memory on the page that was just closed.
// Optional feature macro: BX_CHECK_EN. When it is defined, a word whose bx field
// differs from the current event's bx is discarded and counted in bx_err_cnt.
module mem_writein_demux #(
    parameter int unsigned NMEM        = 12,
    parameter int unsigned DATA_W      = 45,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned NITEMS_ADDR = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_event,
    input  logic [51:0]       mem_dat_stream,
    input  logic              valid,
    output logic              wr_en,
    output logic [3:0]        wr_sel,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              page,
    output logic              flush_busy,
    output logic              counts_done,
    output logic              drop,
    output logic              overrun
`ifdef BX_CHECK_EN
    ,
    output logic [7:0]        bx_err_cnt
`endif
);

    localparam int unsigned SRC_W = 4;
    localparam int unsigned BX_W  = 3;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt       [NMEM];
    logic [CNT_W-1:0]   flush_cnt [NMEM];
    logic [SRC_W-1:0]   flush_idx;
    logic               flush_page;
    logic [BX_W-1:0]    bx_cur;

    logic [BX_W-1:0]    word_bx_c;
    logic [SRC_W-1:0]   word_src_c;
    logic [DATA_W-1:0]  word_data_c;
    logic               src_ok_c;
    logic               bx_ok_c;
    logic               full_c;
    logic               accept_c;
    logic               drop_evt_c;
    logic               page_eff_c;
    logic [CNT_W-1:0]   cur_cnt_c;
    logic               flush_fire_c;
    logic               flush_last_c;
    logic               cnt_zero_c;

    assign word_bx_c   = mem_dat_stream[51:49];
    assign word_src_c  = mem_dat_stream[48:45];
    assign word_data_c = mem_dat_stream[44:0];

`ifdef BX_CHECK_EN
    logic               bx_bad_c;
    logic [BX_W-1:0]    bx_exp_c;

    // Words arriving with new_event already belong to the next bx
    assign bx_exp_c = new_event ? bx_cur + BX_W'(1) : bx_cur;
    assign bx_ok_c  = (word_bx_c == bx_exp_c);
    assign bx_bad_c = valid && src_ok_c && !bx_ok_c;
`else
    logic               bx_unused_c;

    assign bx_ok_c     = 1'b1;
    assign bx_unused_c = ^word_bx_c;
`endif

    // Word classification; a word in the new_event cycle sees cleared counts and the new page
    always_comb begin
        src_ok_c   = (word_src_c < SRC_W'(NMEM));
        page_eff_c = new_event ? ~page : page;
        cur_cnt_c  = '0;
        if (!new_event && src_ok_c) begin
            cur_cnt_c = cnt[word_src_c];
        end
        full_c     = (cur_cnt_c == CNT_W'(NITEMS_ADDR));
        accept_c   = valid && src_ok_c && bx_ok_c && !full_c;
        drop_evt_c = valid && (!src_ok_c || (bx_ok_c && full_c));
    end

    // Count flush uses the bus only when no data write claims it
    always_comb begin
        flush_fire_c = (state == FLUSH) && !new_event && !accept_c;
        flush_last_c = flush_fire_c && (flush_idx == SRC_W'(NMEM - 1));
        cnt_zero_c   = 1'b1;
        for (int unsigned i = 0; i < NMEM; i++) begin
            if (cnt[i] != '0) begin
                cnt_zero_c = 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        if (new_event) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                IDLE:    if (valid) state_nxt = RECV;
                RECV:    state_nxt = RECV;
                FLUSH:   if (flush_last_c) state_nxt = (cnt_zero_c && !accept_c) ? IDLE : RECV;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Write bus, counters, page swap and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_sel      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            page        <= 1'b0;
            flush_busy  <= 1'b0;
            counts_done <= 1'b0;
            drop        <= 1'b0;
            overrun     <= 1'b0;
            flush_idx   <= '0;
            flush_page  <= 1'b0;
            bx_cur      <= '0;
            for (int unsigned i = 0; i < NMEM; i++) begin
                cnt[i]       <= '0;
                flush_cnt[i] <= '0;
            end
        end else begin
            wr_en       <= 1'b0;
            counts_done <= 1'b0;

            if (accept_c) begin
                wr_en   <= 1'b1;
                wr_sel  <= word_src_c;
                wr_addr <= {page_eff_c, cur_cnt_c[ADDR_W-1:0]};
                wr_data <= word_data_c;
            end else if (flush_fire_c) begin
                wr_en     <= 1'b1;
                wr_sel    <= flush_idx;
                wr_addr   <= {flush_page, ADDR_W'(NITEMS_ADDR)};
                wr_data   <= DATA_W'(flush_cnt[flush_idx]);
                flush_idx <= flush_idx + SRC_W'(1);
                if (flush_last_c) begin
                    counts_done <= 1'b1;
                    flush_busy  <= 1'b0;
                end
            end

            if (new_event) begin
                for (int unsigned i = 0; i < NMEM; i++) begin
                    flush_cnt[i] <= cnt[i];
                    cnt[i]       <= '0;
                end
                page       <= ~page;
                flush_page <= page;
                bx_cur     <= bx_cur + BX_W'(1);
                flush_idx  <= '0;
                flush_busy <= 1'b1;
                if (flush_busy) begin
                    overrun <= 1'b1;
                end
            end

            if (accept_c) begin
                cnt[word_src_c] <= cur_cnt_c + CNT_W'(1);
            end

            if (drop_evt_c) begin
                drop <= 1'b1;
            end
        end
    end

`ifdef BX_CHECK_EN
    // Saturating count of words rejected for a bx mismatch
    always_ff @(posedge clk) begin
        if (reset) begin
            bx_err_cnt <= '0;
        end else if (bx_bad_c && (bx_err_cnt != 8'hFF)) begin
            bx_err_cnt <= bx_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_writein_demux.sv
// tb_mem_writein_demux: randomized and directed stimulus for mem_writein_demux.
// The reference model tracks per-event item counts, the open page and a queue
// of pending count writes. Expected bus writes go into a scoreboard queue that
// a negedge monitor drains whenever wr_en is high.
module tb_mem_writein_demux;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_event;
    logic [51:0] mem_dat_stream;
    logic        valid;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [5:0]  wr_addr;
    logic [44:0] wr_data;
    logic        page;
    logic        flush_busy;
    logic        counts_done;
    logic        drop;
    logic        overrun;
`ifdef BX_CHECK_EN
    logic [7:0]  bx_err_cnt;
`endif

    always #5 clk = ~clk;

    mem_writein_demux dut (
        .clk            (clk),
        .reset          (reset),
        .new_event      (new_event),
        .mem_dat_stream (mem_dat_stream),
        .valid          (valid),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .page           (page),
        .flush_busy     (flush_busy),
        .counts_done    (counts_done),
        .drop           (drop),
        .overrun        (overrun)
`ifdef BX_CHECK_EN
        ,
        .bx_err_cnt     (bx_err_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  sel;
        logic [5:0]  addr;
        logic [44:0] data;
        logic        done;
    } wr_t;

    typedef struct {
        int sel;
        int cnt;
        bit pg;
        bit last;
    } fl_t;

    wr_t expq[$];
    fl_t flq[$];

    int       vectors = 0;
    int       miscompares = 0;
    int       m_cnt[12];
    bit       m_page;
    bit [2:0] m_bx;
    bit       m_drop;
    bit       m_overrun;
    int       m_bxerr;

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) m_cnt[i] = 0;
        m_page    = 1'b0;
        m_bx      = 3'd0;
        m_drop    = 1'b0;
        m_overrun = 1'b0;
        m_bxerr   = 0;
        flq.delete();
    endfunction

    function automatic logic [44:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[44:0];
    endfunction

    // Status outputs versus the model after the most recent clock edge
    task automatic check_flags();
        bit busy_exp;
        busy_exp = (flq.size() != 0);
        vectors++;
        if ({page, drop, overrun, flush_busy} !== {m_page, m_drop, m_overrun, busy_exp}) begin
            miscompares++;
            $display("FAIL status page/drop/overrun/flush_busy: got %b%b%b%b want %b%b%b%b at %0t",
                     page, drop, overrun, flush_busy, m_page, m_drop, m_overrun, busy_exp, $time);
        end
`ifdef BX_CHECK_EN
        vectors++;
        if (bx_err_cnt !== 8'(m_bxerr)) begin
            miscompares++;
            $display("FAIL bx_err_cnt: got %0d want %0d at %0t", bx_err_cnt, m_bxerr, $time);
        end
`endif
    endtask

    // One clock of stimulus: check status, advance the model, drive inputs
    task automatic step(input bit ne, input bit v, input logic [2:0] bx,
                        input logic [3:0] src, input logic [44:0] d);
        bit  acc;
        fl_t f;
        wr_t w;
        check_flags();
        if (ne) begin
            if (flq.size() != 0) m_overrun = 1'b1;
            flq.delete();
            for (int i = 0; i < 12; i++) begin
                f = '{i, m_cnt[i], m_page, (i == 11)};
                flq.push_back(f);
                m_cnt[i] = 0;
            end
            m_page = ~m_page;
            m_bx   = m_bx + 3'd1;
        end
        acc = 1'b0;
        if (v) begin
            if (src >= 4'd12) m_drop = 1'b1;
`ifdef BX_CHECK_EN
            else if (bx != m_bx) begin
                if (m_bxerr < 255) m_bxerr++;
            end
`endif
            else if (m_cnt[src] >= 31) m_drop = 1'b1;
            else begin
                w = '{src, {m_page, 5'(m_cnt[src])}, d, 1'b0};
                expq.push_back(w);
                m_cnt[src]++;
                acc = 1'b1;
            end
        end
        if (!ne && !acc && flq.size() != 0) begin
            f = flq.pop_front();
            w = '{4'(f.sel), {f.pg, 5'd31}, 45'(f.cnt), f.last};
            expq.push_back(w);
        end
        new_event      = ne;
        valid          = v;
        mem_dat_stream = {bx, src, d};
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'd0, 45'd0);
    endtask

    task automatic word(input logic [3:0] src, input logic [44:0] d);
        step(1'b0, 1'b1, m_bx, src, d);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        new_event = 1'b0;
        valid     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: sel=%0d addr=%h data=%h, none expected at %0t",
                         wr_sel, wr_addr, wr_data, $time);
            end else begin
                e = expq.pop_front();
                if (wr_sel !== e.sel || wr_addr !== e.addr || wr_data !== e.data || counts_done !== e.done) begin
                    miscompares++;
                    $display("FAIL write: got sel=%0d addr=%h data=%h done=%b want sel=%0d addr=%h data=%h done=%b at %0t",
                             wr_sel, wr_addr, wr_data, counts_done, e.sel, e.addr, e.data, e.done, $time);
                end
            end
        end else if (counts_done === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL counts_done_without_write: got 1 want 0 at %0t", $time);
        end
    end

    initial begin
        bit        ne;
        bit        v;
        bit [2:0]  bx;
        bit [3:0]  src;

        reset          = 1'b1;
        new_event      = 1'b0;
        valid          = 1'b0;
        mem_dat_stream = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        vectors++;
        if (wr_en !== 1'b0 || counts_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: wr_en=%b counts_done=%b want 0 0", wr_en, counts_done);
        end

        // Three words to memory 2, then a traffic-free flush
        word(4'd2, 45'h0A);
        word(4'd2, 45'h0B);
        word(4'd2, 45'h0C);
        idle(2);
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(16);

        // Data every cycle while a flush is pending: data owns the bus
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        for (int i = 0; i < 12; i++) word(4'($urandom_range(0, 11)), rnd_data());
        idle(16);

        // Fill memory 5 past its 31-word capacity
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(14);
        for (int i = 0; i < 32; i++) word(4'd5, rnd_data());
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(16);

        // Illegal source, then back-to-back events forcing an overrun restart
        word(4'd13, rnd_data());
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(4);
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(16);

        // Word tagged with the next bx value
        step(1'b0, 1'b1, m_bx + 3'd1, 4'd3, rnd_data());
        idle(3);

        // Reset in the middle of a flush: no further count writes
        word(4'd7, rnd_data());
        step(1'b1, 1'b0, 3'd0, 4'd0, 45'd0);
        idle(4);
        apply_reset();
        idle(20);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ne  = ($urandom_range(0, 31) == 0);
            v   = ($urandom_range(0, 9) < 6);
            src = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(12, 15));
            bx  = m_bx + (ne ? 3'd1 : 3'd0);
            if ($urandom_range(0, 19) == 0) bx = 3'($urandom_range(0, 7));
            step(ne, v, bx, src, rnd_data());
        end
        idle(20);

        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: %0d expected writes never seen, want 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
